// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder.
//   adder_state_t : controller states (IDLE, RUN, DONE)
//   DEF_WIDTH     : default operand/sum width
//   DEF_CHUNK     : default bits added per cycle
//   idx_width()   : width of the chunk index register (clog2 of the chunk count, at least 1)
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done handshake bundle for the chunked serial adder.
//   start, a, b, cin : request and operands (driven by the master)
//   busy, done       : progress status (driven by the adder)
//   sum, cout        : registered result (driven by the adder)
interface chunked_serial_adder_if #(
    parameter int unsigned WIDTH = chunked_serial_adder_pkg::DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/chunked_serial_adder_chunk_ripple_adder.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
//   a, b : N-bit addends
//   cin  : carry in
//   s    : N-bit sum
//   cout : carry out of the top bit
module chunk_ripple_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[N];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that adds CHUNK bits per clock, holding the
// inter-chunk carry in a register. Operands are captured on an accepted start.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of the start/busy/done handshake (operands in, sum/cout out)
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input logic                  clk,
    input logic                  reset,
    chunked_serial_adder_if.slave bus
);

    localparam int unsigned     NCHUNK   = WIDTH / CHUNK;
    localparam int unsigned     IW       = idx_width(NCHUNK);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CMASK   = WIDTH'({CHUNK{1'b1}});

    adder_state_t     state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_r;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;

    // Chunk selection/insertion is done with shifts so the index arithmetic
    // stays a plain 32-bit quantity regardless of WIDTH.
    assign base     = 32'(idx) * CHUNK;
    assign a_chunk  = CHUNK'(op_a >> base);
    assign b_chunk  = CHUNK'(op_b >> base);
    assign acc_next = (acc & ~(CMASK << base)) | (WIDTH'(s_chunk) << base);

    chunk_ripple_adder #(.N(CHUNK)) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (s_chunk),
        .cout (c_chunk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= c_chunk;
                    idx   <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        // Result includes the slice produced on this same edge.
                        sum_r  <= acc_next;
                        cout_r <= c_chunk;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: a 16/4 build and an 8/8 build
// share clock and reset; expected {cout,sum} values are queued when a request
// is driven and popped when done is observed.
module tb_chunked_serial_adder;

    logic clk;
    logic reset;

    int n_checks   = 0;
    int n_fail     = 0;
    int done16_cnt = 0;
    int done8_cnt  = 0;

    logic [16:0] q16[$];
    logic [8:0]  q8[$];

    chunked_serial_adder_if #(.WIDTH(16)) m16 ();
    chunked_serial_adder_if #(.WIDTH(8))  m8 ();

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (m16)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (m8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m16.done === 1'b1) done16_cnt++;
        if (m8.done === 1'b1)  done8_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request on the 16-bit bus; returns at the negedge after acceptance.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        m16.start = 1'b1;
        m16.a     = a;
        m16.b     = b;
        m16.cin   = cin;
        q16.push_back({1'b0, a} + {1'b0, b} + {16'b0, cin});
        @(negedge clk);
        m16.start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts negedges, bcnt counts busy-high samples.
    task automatic wait16(output int lat, output int bcnt, output bit ok);
        lat  = 0;
        bcnt = (m16.busy === 1'b1) ? 1 : 0;
        ok   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (m16.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (m16.busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        m16.start = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0;
        m8.start  = 1'b0; m8.a  = '0; m8.b  = '0; m8.cin  = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m16.busy, m16.done, m16.cout, m16.sum} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset16: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     m16.busy, m16.done, m16.cout, m16.sum);
        end
        n_checks++;
        if ({m8.busy, m8.done, m8.cout, m8.sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     m8.busy, m8.done, m8.cout, m8.sum);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bcnt;
        bit ok;
        logic [16:0] exp;
        issue16(16'h1234, 16'h4321, 1'b0);
        wait16(lat, bcnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: no done within 20 cycles");
            q16.delete();
            return;
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, want 4", lat);
        end
        n_checks++;
        if (bcnt !== 4) begin
            n_fail++;
            $display("FAIL basic_busy: busy high %0d cycles, want 4", bcnt);
        end
        n_checks++;
        if (m16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: got %b, want 0", m16.busy);
        end
        exp = q16.pop_front();
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL basic_result: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
        n_checks++;
        if (exp !== 17'h05555) begin
            n_fail++;
            $display("FAIL basic_model: model %h, want 05555", exp);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        issue16(16'hA5A5, 16'h0F0F, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({m16.busy, m16.done, m16.cout, m16.sum} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     m16.busy, m16.done, m16.cout, m16.sum);
        end
        q16.delete();
        c0 = done16_cnt;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (done16_cnt !== c0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", done16_cnt - c0);
        end
        n_checks++;
        if (m16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy=%b, want 0", m16.busy);
        end
    endtask

    task automatic test_carry_ripple;
        int lat, bcnt;
        bit ok;
        logic [16:0] exp;
        issue16(16'hFFFF, 16'h0000, 1'b1);
        wait16(lat, bcnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL carry_timeout: no done within 20 cycles");
            q16.delete();
            return;
        end
        exp = q16.pop_front();
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL carry_result: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
        n_checks++;
        if ({m16.cout, m16.sum} !== 17'h10000) begin
            n_fail++;
            $display("FAIL carry_const: got %h, want 10000", {m16.cout, m16.sum});
        end
    endtask

    task automatic test_start_while_busy;
        int lat, bcnt, c0;
        bit ok;
        logic [16:0] exp;
        issue16(16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        c0        = done16_cnt;
        m16.start = 1'b1;
        m16.a     = 16'h0001;
        m16.b     = 16'h0001;
        m16.cin   = 1'b0;
        @(negedge clk);
        m16.start = 1'b0;
        wait16(lat, bcnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_timeout: no done within 20 cycles");
            q16.delete();
            return;
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d further edges, want 2", lat);
        end
        exp = q16.pop_front();
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL ignore_result: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (done16_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL ignore_single_done: got %0d done pulses, want 1", done16_cnt - c0);
        end
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL ignore_hold: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        bit ok;
        logic [16:0] exp;
        issue16(16'h00FF, 16'h0001, 1'b0);
        wait16(lat, bcnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_first_timeout: no done within 20 cycles");
            q16.delete();
            return;
        end
        exp = q16.pop_front();
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_first_result: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
        // Still in the DONE cycle: request the next addition immediately.
        m16.start = 1'b1;
        m16.a     = 16'h7FFF;
        m16.b     = 16'h0001;
        m16.cin   = 1'b0;
        q16.push_back({1'b0, 16'h7FFF} + {1'b0, 16'h0001});
        @(negedge clk);
        m16.start = 1'b0;
        n_checks++;
        if ({m16.busy, m16.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", m16.busy, m16.done);
        end
        wait16(lat, bcnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_second_timeout: no done within 20 cycles");
            q16.delete();
            return;
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d edges, want 4", lat);
        end
        exp = q16.pop_front();
        n_checks++;
        if ({m16.cout, m16.sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %h, want %h", {m16.cout, m16.sum}, exp);
        end
    endtask

    task automatic test_random16;
        int lat, bcnt;
        bit ok;
        logic [16:0] exp;
        logic [15:0] ra, rb;
        logic        rc;
        for (int n = 0; n < 175; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            issue16(ra, rb, rc);
            // Scramble inputs after acceptance; only captured copies may matter.
            m16.a   = ~ra;
            m16.b   = 16'($urandom);
            m16.cin = ~rc;
            wait16(lat, bcnt, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand16_timeout: op %0d no done", n);
                q16.delete();
                return;
            end
            exp = q16.pop_front();
            if ({m16.cout, m16.sum} !== exp || lat !== 4) begin
                n_fail++;
                $display("FAIL rand16_result: op %0d %h+%h+%b got %h lat %0d, want %h lat 4",
                         n, ra, rb, rc, {m16.cout, m16.sum}, lat, exp);
            end
        end
    endtask

    task automatic test_random8;
        int lat;
        bit ok;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rc;
        for (int n = 0; n < 175; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            @(negedge clk);
            m8.start = 1'b1;
            m8.a     = ra;
            m8.b     = rb;
            m8.cin   = rc;
            q8.push_back({1'b0, ra} + {1'b0, rb} + {8'b0, rc});
            @(negedge clk);
            m8.start = 1'b0;
            m8.a     = ~ra;
            m8.cin   = ~rc;
            lat = 0;
            ok  = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                lat++;
                if (m8.done === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand8_timeout: op %0d no done", n);
                q8.delete();
                return;
            end
            exp = q8.pop_front();
            if ({m8.cout, m8.sum} !== exp || lat !== 1) begin
                n_fail++;
                $display("FAIL rand8_result: op %0d %h+%h+%b got %h lat %0d, want %h lat 1",
                         n, ra, rb, rc, {m8.cout, m8.sum}, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_carry_ripple();
        test_start_while_busy();
        test_back_to_back();
        test_random16();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised two-operand adder. Adds WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks.
- Trades latency for a short carry chain. It is the sequential, width-generic successor to the team's fixed 4-bit ripple adder.
- Sits behind a start/busy/done handshake so datapath controllers can issue additions without knowing the width.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. Must be at least 1.
- NCHUNK, WIDTH/CHUNK, derived localparam giving the number of RUN cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when sum and cout become valid.
- sum  out  WIDTH  registered result; holds until the next completion.
- cout  out  1  registered carry-out of the most significant chunk.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
  - On reset: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal operand registers, chunk index and carry register all clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at the edge: capture a, b and cin; set idx=0; carry=cin; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), on each edge:
  - Compute {c, s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry.
  - Write s into the accumulator slice idx; set carry=c; increment idx.
  - When idx==NCHUNK-1 at the edge: load sum from the full accumulator (including the slice written this edge), load cout from c, and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 at this edge: a new operation is accepted (back-to-back) and the FSM goes to RUN. Otherwise it returns to IDLE.
- Latency: done rises exactly NCHUNK rising edges after the accepting start edge. Throughput is one result per NCHUNK+1 cycles.
- Busy window: busy is high from the edge after acceptance through the edge that produces done.
- start while busy: ignored. Operands are not recaptured and there is no queueing.
- Operand stability: a, b and cin may change freely after acceptance because only the captured copies are used.
- Width rule: sum is the result modulo 2^WIDTH, and {cout, sum} == a+b+cin as a WIDTH+1-bit quantity.
- Output hold: sum and cout change only on the edge that raises done, or on reset. They are stable between completions.
- Degenerate case CHUNK==WIDTH: NCHUNK=1, giving a 1-cycle RUN and done one edge after acceptance.
- Reset mid-operation: the FSM aborts to IDLE, outputs clear to 0, and no done is produced for the aborted operation.

Decomposition:
- Shared package (adder_pkg):
  - adder_state_t enum {IDLE, RUN, DONE}.
  - Default WIDTH/CHUNK constants.
  - Index-width helper (clog2 of NCHUNK, minimum 1).
- Sub-module chunk_ripple_adder:
  - Parameter N (=CHUNK); combinational N-bit ripple adder built from full-adder cells.
  - Ports a, b, cin in; s, cout out.
  - Instanced once in the RUN datapath.

Test Plan:
1. Reset for 2 cycles -> busy=0, done=0, sum=16'h0000, cout=0. Assert reset mid-RUN (2nd RUN cycle) -> same values immediately; no done pulse follows.
2. start, a=16'h1234, b=16'h4321, cin=0 -> done exactly 4 edges later; sum=16'h5555, cout=0; busy high for 4 cycles.
3. start, a=16'hFFFF, b=16'h0000, cin=1 -> carry ripples through every chunk; sum=16'h0000, cout=1.
4. start a=16'h8000, b=16'h8000, cin=0. Then assert start on RUN cycle 2 with a=1, b=1 -> second request ignored; single done with sum=16'h0000, cout=1; no second done.
5. Back-to-back: first op 16'h00FF+16'h0001 (cin=0), then start asserted during its DONE cycle with 16'h7FFF+16'h0001 -> first result sum=16'h0100, cout=0. Second done 4 edges later with sum=16'h8000, cout=0.
6. Randomised: 175 ops, with WIDTH=16/CHUNK=4 and a second build with WIDTH=8/CHUNK=8. Each {cout,sum} is compared against a+b+cin; each mismatch is logged to the results file; zero mismatches are required.
